// File: rtl/flash_countdown.sv
// flash_countdown: two-digit BCD seconds countdown timed by the slow square
// wave from the divider stage. The divided wave is synchronised and
// edge-detected into a one-cycle enable; it never clocks anything. When the
// count expires, the LED bank flashes for a fixed number of ticks and the
// timer then returns to idle with the start value reloaded.
module flash_countdown #(
    parameter int INIT_SEC     = 30,
    parameter int FLASH_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start,
    input  logic        clear,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic [15:0] led,
    output logic [1:0]  state,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] FLASH = 2'd3;

    localparam logic [3:0] INIT_TENS = 4'(INIT_SEC / 10);
    localparam logic [3:0] INIT_ONES = 4'(INIT_SEC % 10);

    // Flash counter has to hold values 0..FLASH_CYCLES.
    localparam int FW = (FLASH_CYCLES < 2) ? 1 : $clog2(FLASH_CYCLES + 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES);
    localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

    logic          tick_meta;
    logic          tick_sync;
    logic          tick_prev;
    logic          tick;

    logic [FW-1:0] flash_cnt;

    logic [1:0]    state_next;
    logic [3:0]    tens_next;
    logic [3:0]    ones_next;
    logic [15:0]   led_next;
    logic [FW-1:0] flash_cnt_next;
    logic          done_next;

    // Two-flop synchroniser for the divided wave plus the previous-level flop
    // used for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_meta <= 1'b0;
            tick_sync <= 1'b0;
            tick_prev <= 1'b0;
        end else begin
            tick_meta <= tick_in;
            tick_sync <= tick_meta;
            tick_prev <= tick_sync;
        end
    end

    // One-cycle tick on each rising edge of the synchronised wave; it is
    // consumed by the state register on the third clk edge after tick_in rises.
    assign tick = tick_sync & ~tick_prev;

    // Next-state and next-output logic; clear beats start, start beats tick.
    always_comb begin
        state_next     = state;
        tens_next      = bcd_tens;
        ones_next      = bcd_ones;
        led_next       = led;
        flash_cnt_next = flash_cnt;

        if (clear) begin
            state_next     = IDLE;
            tens_next      = INIT_TENS;
            ones_next      = INIT_ONES;
            led_next       = 16'h0000;
            flash_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    led_next = 16'h0000;
                    if (start) begin
                        state_next = RUN;
                        led_next   = {15'b0, tick_sync};
                    end
                end

                RUN: begin
                    led_next = {15'b0, tick_sync};
                    if (start) begin
                        state_next = PAUSE;
                        led_next   = 16'h0000;
                    end else if (tick) begin
                        if (bcd_tens == 4'd0 && bcd_ones == 4'd0) begin
                            state_next     = FLASH;
                            led_next       = 16'hFFFF;
                            flash_cnt_next = FLASH_ONE;
                        end else if (bcd_ones == 4'd0) begin
                            ones_next = 4'd9;
                            tens_next = bcd_tens - 4'd1;
                        end else begin
                            ones_next = bcd_ones - 4'd1;
                        end
                    end
                end

                PAUSE: begin
                    led_next = 16'h0000;
                    if (start) begin
                        state_next = RUN;
                        led_next   = {15'b0, tick_sync};
                    end
                end

                FLASH: begin
                    if (tick) begin
                        if (flash_cnt == FLASH_LAST) begin
                            state_next     = IDLE;
                            tens_next      = INIT_TENS;
                            ones_next      = INIT_ONES;
                            led_next       = 16'h0000;
                            flash_cnt_next = '0;
                        end else begin
                            led_next       = ~led;
                            flash_cnt_next = flash_cnt + FLASH_ONE;
                        end
                    end
                end

                default: begin
                    state_next     = IDLE;
                    tens_next      = INIT_TENS;
                    ones_next      = INIT_ONES;
                    led_next       = 16'h0000;
                    flash_cnt_next = '0;
                end
            endcase
        end

        done_next = (state_next == FLASH);
    end

    // Registered state and outputs so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bcd_tens  <= INIT_TENS;
            bcd_ones  <= INIT_ONES;
            led       <= 16'h0000;
            flash_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            bcd_tens  <= tens_next;
            bcd_ones  <= ones_next;
            led       <= led_next;
            flash_cnt <= flash_cnt_next;
            done      <= done_next;
        end
    end

endmodule
